// File: rtl/unit_pkg.sv
// rtl/unit_pkg.sv - shared encodings and grid helpers for the turn controller
package unit_pkg;

    typedef logic [4:0] coord_t;

    localparam logic [1:0] U_MOVE   = 2'b00;
    localparam logic [1:0] U_ATTACK = 2'b01;
    localparam logic [1:0] U_HIT    = 2'b10;
    localparam logic [1:0] U_IDLE   = 2'b11;

    localparam logic [2:0] S_SELECT = 3'd0;
    localparam logic [2:0] S_MOVE   = 3'd1;
    localparam logic [2:0] S_ATTACK = 3'd2;
    localparam logic [2:0] S_ANIM   = 3'd3;
    localparam logic [2:0] S_ENEMY  = 3'd4;
    localparam logic [2:0] S_WIN    = 3'd5;
    localparam logic [2:0] S_LOSE   = 3'd6;

    function automatic logic [5:0] manhattan(input coord_t x0, input coord_t y0,
                                             input coord_t x1, input coord_t y1);
        logic [5:0] dx;
        logic [5:0] dy;
        dx = (x0 > x1) ? 6'(x0 - x1) : 6'(x1 - x0);
        dy = (y0 > y1) ? 6'(y0 - y1) : 6'(y1 - y0);
        return dx + dy;
    endfunction

endpackage

// File: rtl/grid_cursor.sv
// rtl/grid_cursor.sv - clamped tile cursor with opposing-pulse cancellation
module grid_cursor
    import unit_pkg::*;
#(
    parameter int GRID_W = 20,
    parameter int GRID_H = 15,
    parameter int POS_W  = 9,
    parameter int X0     = 7,
    parameter int Y0     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             mv_left,
    input  logic             mv_right,
    input  logic             mv_up,
    input  logic             mv_down,
    output logic [4:0]       x,
    output logic [4:0]       y,
    output logic [POS_W-1:0] pos
);

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= 5'(X0);
            y <= 5'(Y0);
        end else if (!freeze) begin
            if (mv_left && !mv_right && x != 5'd0)
                x <= x - 5'd1;
            else if (mv_right && !mv_left && x != 5'(GRID_W - 1))
                x <= x + 5'd1;
            if (mv_up && !mv_down && y != 5'd0)
                y <= y - 5'd1;
            else if (mv_down && !mv_up && y != 5'(GRID_H - 1))
                y <= y + 5'd1;
        end
    end

    assign pos = POS_W'(32'(y) * GRID_W + 32'(x));

endmodule

// File: rtl/unit_turn_ctrl.sv
// rtl/unit_turn_ctrl.sv - player/enemy phase FSM, unit positions, HP and animation states
module unit_turn_ctrl
    import unit_pkg::*;
#(
    parameter int GRID_W      = 20,
    parameter int GRID_H      = 15,
    parameter int N_UNITS     = 4,
    parameter int POS_W       = 9,
    parameter int IDX_W       = 2,
    parameter int HP_W        = 4,
    parameter int UNIT_HP     = 8,
    parameter int MONSTER_HP  = 10,
    parameter int ATK_DMG     = 3,
    parameter int MOVE_RANGE  = 3,
    parameter int ATK_RANGE   = 2,
    parameter int ANIM_LEN    = 16,
    parameter int CUR_X0      = 7,
    parameter int CUR_Y0      = 7,
    parameter logic [N_UNITS*POS_W-1:0] INIT_POS = {9'd170, 9'd160, 9'd167, 9'd125},
    parameter int MONSTER_POS = 130
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       anim_tick,
    input  logic                       mv_left,
    input  logic                       mv_right,
    input  logic                       mv_up,
    input  logic                       mv_down,
    input  logic                       select_pulse,
    input  logic                       cancel_pulse,
    input  logic                       end_turn_pulse,
    input  logic [7:0]                 rand_num,
    output logic [POS_W-1:0]           cursor_pos,
    output logic [4:0]                 cursor_x,
    output logic [4:0]                 cursor_y,
    output logic [N_UNITS*POS_W-1:0]   unit_pos,
    output logic [2*N_UNITS-1:0]       unit_state,
    output logic [N_UNITS*HP_W-1:0]    unit_hp,
    output logic [N_UNITS-1:0]         unit_alive,
    output logic [HP_W-1:0]            monster_hp,
    output logic                       monster_state,
    output logic [IDX_W-1:0]           active_idx,
    output logic [2:0]                 phase,
    output logic                       game_over,
    output logic                       win
);

    localparam int     CNT_W  = $clog2(ANIM_LEN + 1);
    localparam coord_t MON_X  = coord_t'(MONSTER_POS % GRID_W);
    localparam coord_t MON_Y  = coord_t'(MONSTER_POS / GRID_W);
    localparam logic [5:0] MOVE_R = 6'(MOVE_RANGE);
    localparam logic [5:0] ATK_R  = 6'(ATK_RANGE);

    function automatic coord_t init_x(input int i);
        logic [POS_W-1:0] p;
        p = INIT_POS[i*POS_W +: POS_W];
        return coord_t'(32'(p) % GRID_W);
    endfunction

    function automatic coord_t init_y(input int i);
        logic [POS_W-1:0] p;
        p = INIT_POS[i*POS_W +: POS_W];
        return coord_t'(32'(p) / GRID_W);
    endfunction

    // Requested index first, then the next alive index upward with wrap.
    function automatic logic [IDX_W-1:0] pick_target(input logic [IDX_W-1:0] r,
                                                     input logic [N_UNITS-1:0] alv);
        int base;
        int j;
        logic [IDX_W-1:0] pick;
        base = int'(r) % N_UNITS;
        pick = IDX_W'(base);
        for (int k = N_UNITS - 1; k >= 0; k--) begin
            j = (base + k) % N_UNITS;
            if (alv[j]) pick = IDX_W'(j);
        end
        return pick;
    endfunction

    function automatic logic [2:0] post_phase(input logic [HP_W-1:0] m, input logic done);
        if (m == '0)
            return S_WIN;
        else if (done)
            return S_ENEMY;
        else
            return S_SELECT;
    endfunction

    coord_t             ux [N_UNITS];
    coord_t             uy [N_UNITS];
    logic [HP_W-1:0]    hp [N_UNITS];
    logic [N_UNITS-1:0] acted;
    logic [IDX_W-1:0]   tgt;
    logic [CNT_W-1:0]   cnt;

    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               occupied;
    logic               own_tile;
    logic [5:0]         move_dist;
    logic [5:0]         atk_dist;
    logic               atk_ok;
    logic               anim_last;
    logic [HP_W-1:0]    mhp_after;
    logic [N_UNITS-1:0] act_oh;
    logic [N_UNITS-1:0] acted_after;
    logic               all_done;
    logic [IDX_W-1:0]   tgt_next;
    logic [HP_W-1:0]    hit_hp;
    logic [N_UNITS-1:0] tgt_oh;
    logic [N_UNITS-1:0] alive_after_hit;
    logic               unused_rand;

    assign unused_rand = ^rand_num;

    grid_cursor #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .POS_W  (POS_W),
        .X0     (CUR_X0),
        .Y0     (CUR_Y0)
    ) u_cursor (
        .clk      (clk),
        .rst      (rst),
        .freeze   (game_over),
        .mv_left  (mv_left),
        .mv_right (mv_right),
        .mv_up    (mv_up),
        .mv_down  (mv_down),
        .x        (cursor_x),
        .y        (cursor_y),
        .pos      (cursor_pos)
    );

    always_comb begin
        unit_alive = '0;
        for (int i = 0; i < N_UNITS; i++)
            unit_alive[i] = (hp[i] != '0);
    end

    // Dead units free their tile; the monster tile is always blocked.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        occupied  = (cursor_x == MON_X) && (cursor_y == MON_Y);
        for (int i = 0; i < N_UNITS; i++) begin
            if (unit_alive[i] && ux[i] == cursor_x && uy[i] == cursor_y) begin
                occupied = 1'b1;
                if (!acted[i] && !sel_found) begin
                    sel_found = 1'b1;
                    sel_idx   = IDX_W'(i);
                end
            end
        end
    end

    assign own_tile        = (ux[active_idx] == cursor_x) && (uy[active_idx] == cursor_y);
    assign move_dist       = manhattan(ux[active_idx], uy[active_idx], cursor_x, cursor_y);
    assign atk_dist        = manhattan(ux[active_idx], uy[active_idx], MON_X, MON_Y);
    assign atk_ok          = (cursor_x == MON_X) && (cursor_y == MON_Y) && (atk_dist <= ATK_R);
    assign anim_last       = anim_tick && (cnt == CNT_W'(ANIM_LEN - 1));
    assign mhp_after       = (monster_hp > HP_W'(ATK_DMG)) ? monster_hp - HP_W'(ATK_DMG) : '0;
    assign act_oh          = N_UNITS'(1) << active_idx;
    assign acted_after     = acted | act_oh;
    assign all_done        = ((acted_after & unit_alive) == unit_alive);
    assign tgt_next        = pick_target(rand_num[IDX_W-1:0], unit_alive);
    assign hit_hp          = (hp[tgt] == '0) ? '0 : hp[tgt] - 1'b1;
    assign tgt_oh          = N_UNITS'(1) << tgt;
    assign alive_after_hit = unit_alive & ~((hit_hp == '0) ? tgt_oh : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_UNITS; i++) begin
                ux[i] <= init_x(i);
                uy[i] <= init_y(i);
                hp[i] <= HP_W'(UNIT_HP);
            end
            acted      <= '0;
            monster_hp <= HP_W'(MONSTER_HP);
            active_idx <= '0;
            phase      <= S_SELECT;
            cnt        <= '0;
            tgt        <= '0;
        end else begin
            case (phase)
                S_SELECT: begin
                    if (select_pulse && sel_found) begin
                        active_idx <= sel_idx;
                        phase      <= S_MOVE;
                    end else if (end_turn_pulse) begin
                        phase <= S_ENEMY;
                        tgt   <= tgt_next;
                        cnt   <= '0;
                    end
                end
                S_MOVE: begin
                    if (select_pulse) begin
                        if (own_tile) begin
                            phase <= S_ATTACK;
                        end else if (!occupied && move_dist <= MOVE_R) begin
                            ux[active_idx] <= cursor_x;
                            uy[active_idx] <= cursor_y;
                            phase          <= S_ATTACK;
                        end
                    end else if (cancel_pulse) begin
                        phase <= S_SELECT;
                    end
                end
                S_ATTACK: begin
                    if (select_pulse) begin
                        if (atk_ok) begin
                            phase <= S_ANIM;
                            cnt   <= '0;
                        end
                    end else if (cancel_pulse) begin
                        acted <= acted_after;
                        phase <= post_phase(monster_hp, all_done);
                        tgt   <= tgt_next;
                        cnt   <= '0;
                    end
                end
                S_ANIM: begin
                    if (anim_last) begin
                        monster_hp <= mhp_after;
                        acted      <= acted_after;
                        phase      <= post_phase(mhp_after, all_done);
                        tgt        <= tgt_next;
                        cnt        <= '0;
                    end else if (anim_tick) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ENEMY: begin
                    if (anim_last) begin
                        hp[tgt] <= hit_hp;
                        acted   <= '0;
                        phase   <= (|alive_after_hit) ? S_SELECT : S_LOSE;
                        cnt     <= '0;
                    end else if (anim_tick) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        unit_pos   = '0;
        unit_hp    = '0;
        unit_state = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            unit_pos[i*POS_W +: POS_W] = POS_W'(32'(uy[i]) * GRID_W + 32'(ux[i]));
            unit_hp[i*HP_W +: HP_W]    = hp[i];
            unit_state[2*i +: 2]       = U_IDLE;
            if (unit_alive[i]) begin
                if (IDX_W'(i) == active_idx && phase == S_MOVE)
                    unit_state[2*i +: 2] = U_MOVE;
                else if (IDX_W'(i) == active_idx && (phase == S_ATTACK || phase == S_ANIM))
                    unit_state[2*i +: 2] = U_ATTACK;
                else if (IDX_W'(i) == tgt && phase == S_ENEMY)
                    unit_state[2*i +: 2] = U_HIT;
            end
        end
    end

    assign monster_state = (phase == S_ENEMY);
    assign game_over     = (phase == S_WIN) || (phase == S_LOSE);
    assign win           = (phase == S_WIN);

endmodule
